// File: rtl/fft_input_loader.sv
// Bit-reversing frame loader feeding the 64-point in-place butterfly; updates on the falling clock edge.
// Optional FFT_LOADER_SCALE_EN: arithmetic right shift by LOG_2_WIDTH of every sample before storage.
module fft_input_loader #(
    parameter int D_WIDTH        = 64,
    parameter int LOG_2_WIDTH    = 6,
    parameter int COMPUTE_CYCLES = 192
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_re,
    input  logic [15:0]               in_im,
    input  logic                      in_last,
    output logic [D_WIDTH-1:0][15:0]  out_re,
    output logic [D_WIDTH-1:0][15:0]  out_im,
    output logic                      start,
    output logic                      busy,
    output logic                      frame_err
);

    localparam int CNT_W = $clog2(COMPUTE_CYCLES + 1);

    typedef enum logic [1:0] {FILL, START, BUSY} state_t;

    state_t                 state_reg, state_next;
    logic [LOG_2_WIDTH-1:0] wr_cnt_reg, wr_cnt_next;
    logic [LOG_2_WIDTH-1:0] wr_addr;
    logic [CNT_W-1:0]       cyc_cnt_reg, cyc_cnt_next;
    logic                   accept;
    logic                   cnt_full;
    logic                   good_frame;
    logic                   bad_frame;
    logic [15:0]            wr_re;
    logic [15:0]            wr_im;
    logic                   start_reg;
    logic                   busy_reg;
    logic                   frame_err_reg;

    assign accept     = in_valid & in_ready;
    assign cnt_full   = (wr_cnt_reg == LOG_2_WIDTH'(D_WIDTH - 1));
    assign good_frame = accept & in_last & cnt_full;
    // A last flag on the wrong beat, or a missing one on the final beat, is a framing error.
    assign bad_frame  = accept & (in_last ^ cnt_full);

    genvar gi;
    generate
        for (gi = 0; gi < LOG_2_WIDTH; gi++) begin : g_bitrev
            assign wr_addr[gi] = wr_cnt_reg[LOG_2_WIDTH-1-gi];
        end
    endgenerate

`ifdef FFT_LOADER_SCALE_EN
    assign wr_re = 16'($signed(in_re) >>> LOG_2_WIDTH);
    assign wr_im = 16'($signed(in_im) >>> LOG_2_WIDTH);
`else
    assign wr_re = in_re;
    assign wr_im = in_im;
`endif

    // State register
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= FILL;
            wr_cnt_reg  <= '0;
            cyc_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            wr_cnt_reg  <= wr_cnt_next;
            cyc_cnt_reg <= cyc_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        wr_cnt_next  = wr_cnt_reg;
        cyc_cnt_next = cyc_cnt_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    if (in_last || cnt_full) begin
                        wr_cnt_next = '0;
                        if (good_frame) begin
                            state_next = START;
                        end
                    end else begin
                        wr_cnt_next = wr_cnt_reg + 1'b1;
                    end
                end
            end
            START: begin
                cyc_cnt_next = CNT_W'(COMPUTE_CYCLES - 1);
                state_next   = BUSY;
            end
            BUSY: begin
                if (cyc_cnt_reg == '0) begin
                    state_next = FILL;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg - 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_reg == FILL);
    end

    // Status flags are registered from the upcoming state so they align with it.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            start_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            start_reg     <= (state_next == START);
            busy_reg      <= (state_next == BUSY);
            frame_err_reg <= bad_frame;
        end
    end

    assign start     = start_reg;
    assign busy      = busy_reg;
    assign frame_err = frame_err_reg;

    generate
        for (gi = 0; gi < D_WIDTH; gi++) begin : g_buf
            logic [15:0] re_reg;
            logic [15:0] im_reg;

            always_ff @(negedge clk or negedge rst) begin
                if (!rst) begin
                    re_reg <= '0;
                    im_reg <= '0;
                end else if (accept && (wr_addr == LOG_2_WIDTH'(gi))) begin
                    re_reg <= wr_re;
                    im_reg <= wr_im;
                end
            end

            assign out_re[gi] = re_reg;
            assign out_im[gi] = im_reg;
        end
    endgenerate

endmodule
